prio_encoder_latched: RTL and testbench
=======================================

# prio_encoder_latched

Parametrised, registered priority encoder: the clocked successor to the combinational 8-to-3 encoders. Request inputs are latched into a pending register, and the highest-priority pending line is presented as a binary code with a valid/ack handshake. Simultaneous and back-to-back requests are never lost. It sits between raw event/interrupt lines and a consumer that services one index at a time.

## Interface
- N, default 8: number of request lines; legal range 2..256.
- W, default $clog2(N): code width; derived, not overridden.
- clk, input, 1: sole clock; all state updates on rising edge.
- rst_n, input, 1: synchronous, active-low reset, sampled on rising edge of clk.
- req, input, N: level request lines; req[i] high in a cycle sets pend[i].
- ack, input, 1: consumer accepts the presented code; meaningful only while valid=1.
- code, output, W: index of the presented request; stable while valid=1.
- valid, output, 1: code is valid and awaiting ack.
- pend, output, N: current pending register, for status/debug.

## Operation
- The pending register is updated every cycle by pend_next = (pend & ~clr_mask) | req.
  - clr_mask is one-hot at code when valid & ack, otherwise zero.
  - If a set and a clear hit the same bit in the same cycle, the set wins and the bit stays pending.
- State machine, 2 states:
  - IDLE: valid=0. If pend != 0, select an index, load code, go to PRESENT. Otherwise stay in IDLE.
  - PRESENT: valid=1 and code is frozen. Newly arriving requests, including higher-priority ones, only update pend.
    - On ack: clear pend[code] and go to IDLE.
    - Without ack: stay in PRESENT.
- Selection in fixed mode: the highest set index of pend wins (index N-1 has top priority).
- ack while in IDLE is ignored and has no side effects.
- req bits are not edge-detected. A line held high re-pends every cycle and is therefore re-granted after each ack.

## Timing
- Reset (rst_n=0 at a clk edge) sets:
  - pend=0, code=0, valid=0, state=IDLE;
  - rotation pointer=N-1 when compiled in.
  - Reset takes priority over every other event, including mid-PRESENT and simultaneous with ack.
- Latency from request to grant:
  - req high at edge k makes pend[i]=1 after edge k.
  - The IDLE→PRESENT load happens at edge k+1, so valid=1 and code=i after edge k+1. Request-to-valid latency is 2 cycles.
- ack sampled high with valid=1 at edge m:
  - valid=0 after edge m, and the bit is cleared.
  - The next grant can appear at the earliest after edge m+1.
  - valid is therefore low for at least one cycle between grants.
- code holds its last value while valid=0.
- Throughput: at most one grant per 2 cycles.

## Configuration
- ROTATE_PRIO_EN undefined: fixed priority as above, with no pointer register.
- ROTATE_PRIO_EN defined: rotating priority using an internal pointer ptr (W bits, reset N-1).
  - Selection searches pend downward from ptr and wraps from 0 to N-1; the first set bit wins.
  - On ack of code g, ptr becomes (g-1) mod N, so g becomes lowest priority.
  - ptr changes only on an accepted ack.
- The port list is identical in both builds.

## Test plan
- Reset check: assert rst_n=0 mid-PRESENT with ack=1 and req=8'hFF, then release with req=0.
  - Required response: pend=0, valid=0, code=0 one edge after reset; no grant afterwards.
- Single request: with N=8, pulse req=8'b0000_1000 for one cycle, then hold ack=1.
  - Required response: valid=1 and code=3 two edges after the pulse edge.
  - After ack: valid=0 and pend=0.
- Fixed priority: pulse req=8'b1000_0001 in one cycle, then ack each grant.
  - Required response: code=7 first, then code=0; valid low for one cycle between them; pend=0 at the end.
- Freeze and hold-off: while code=2 is presented with ack=0 for 5 cycles, pulse req[6].
  - Required response: code stays 2 and valid stays 1. After ack, code=6.
- Set-wins collision: hold req[5]=1 continuously and ack the grant of 5.
  - Required response: pend[5] remains 1 and code=5 is re-granted 2 cycles after the ack edge.
- ROTATE_PRIO_EN defined: hold req=8'b1000_0011 high and ack every grant.
  - Required response: grant sequence 7, 1, 0, 7, 1, 0.
  - Without the macro, the same stimulus gives 7, 7, 7, …

Source files
------------

// File: rtl/prio_encoder_latched.sv
// rtl/prio_encoder_latched.sv - registered priority encoder with pending latch and valid/ack handshake
// Optional rotating priority is compiled in with ROTATE_PRIO_EN; the default build is fixed priority.

module prio_encoder_latched #(
  parameter int N = 8,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         ack,
  output logic [W-1:0] code,
  output logic         valid,
  output logic [N-1:0] pend
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t       state;
  state_t       state_next;
  logic [W-1:0] code_next;
  logic [W-1:0] sel;
  logic         accept;
  logic [N-1:0] clr_mask;
  logic [N-1:0] pend_next;

`ifdef ROTATE_PRIO_EN
  logic [W-1:0] ptr;
  logic [W-1:0] ptr_next;

  // Search downward from ptr, wrapping from 0 back to N-1; first set bit wins.
  always_comb begin : sel_rotate
    int   idx;
    logic found;
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) - k;
      if (idx < 0) begin
        idx = idx + N;
      end
      if (!found && pend[W'(idx)]) begin
        sel   = W'(idx);
        found = 1'b1;
      end
    end
  end
`else
  // Ascending scan so the highest set index is the last one written.
  always_comb begin : sel_fixed
    sel = '0;
    for (int i = 0; i < N; i++) begin
      if (pend[W'(i)]) begin
        sel = W'(i);
      end
    end
  end
`endif

  assign accept    = (state == PRESENT) && ack;
  assign clr_mask  = accept ? (N'(1) << code) : '0;
  // The OR with req comes last so a same-cycle set beats the clear.
  assign pend_next = (pend & ~clr_mask) | req;

  always_comb begin
    state_next = state;
    code_next  = code;
    valid      = 1'b0;
`ifdef ROTATE_PRIO_EN
    ptr_next   = ptr;
`endif
    case (state)
      IDLE: begin
        if (pend != '0) begin
          code_next  = sel;
          state_next = PRESENT;
        end
      end
      PRESENT: begin
        valid = 1'b1;
        if (ack) begin
          state_next = IDLE;
`ifdef ROTATE_PRIO_EN
          ptr_next   = (code == '0) ? W'(N - 1) : code - W'(1);
`endif
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      pend  <= '0;
      code  <= '0;
`ifdef ROTATE_PRIO_EN
      ptr   <= W'(N - 1);
`endif
    end else begin
      state <= state_next;
      pend  <= pend_next;
      code  <= code_next;
`ifdef ROTATE_PRIO_EN
      ptr   <= ptr_next;
`endif
    end
  end

endmodule

// File: tb/tb_prio_encoder_latched.sv
// tb/tb_prio_encoder_latched.sv - directed-vector bench for prio_encoder_latched (N=8)

module tb_prio_encoder_latched;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req;
  logic         ack;
  logic [W-1:0] code;
  logic         valid;
  logic [N-1:0] pend;

  int vectors;
  int miscompares;

  prio_encoder_latched #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .ack   (ack),
    .code  (code),
    .valid (valid),
    .pend  (pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs are then driven and outputs sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int exp_rot [6];

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0;
    req   = '0;
    ack   = 1'b0;
    step();
    step();
    chk("rst_pend", 32'(pend), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_code", 32'(code), 32'h0);
    rst_n = 1'b1;

    // Single request: two-edge latency, then ack clears it
    req = 8'h08;
    step();
    chk("single_pend", 32'(pend), 32'h08);
    chk("single_valid_early", 32'(valid), 32'h0);
    req = '0;
    step();
    chk("single_valid", 32'(valid), 32'h1);
    chk("single_code", 32'(code), 32'h3);
    ack = 1'b1;
    step();
    chk("single_ack_valid", 32'(valid), 32'h0);
    chk("single_ack_pend", 32'(pend), 32'h0);
    chk("single_code_hold", 32'(code), 32'h3);
    // ack with nothing pending in IDLE does nothing
    step();
    chk("idle_ack_valid", 32'(valid), 32'h0);
    chk("idle_ack_pend", 32'(pend), 32'h0);
    ack = 1'b0;

    // Fixed priority 7 then 0; ack held in IDLE must not clear anything
    req = 8'h81;
    step();
    req = '0;
    chk("fix_pend", 32'(pend), 32'h81);
    ack = 1'b1;
    step();
    chk("fix_first_valid", 32'(valid), 32'h1);
    chk("fix_first_code", 32'(code), 32'h7);
    chk("fix_idle_ack_pend", 32'(pend), 32'h81);
    step();
    chk("fix_gap_valid", 32'(valid), 32'h0);
    chk("fix_gap_pend", 32'(pend), 32'h01);
    ack = 1'b0;
    step();
    chk("fix_second_valid", 32'(valid), 32'h1);
    chk("fix_second_code", 32'(code), 32'h0);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("fix_end_valid", 32'(valid), 32'h0);
    chk("fix_end_pend", 32'(pend), 32'h0);

    // Freeze: code 2 stays presented while a higher request arrives
    req = 8'h04;
    step();
    req = '0;
    step();
    chk("frz_code", 32'(code), 32'h2);
    for (int c = 0; c < 5; c++) begin
      req = (c == 2) ? 8'h40 : 8'h00;
      step();
      chk("frz_hold_valid", 32'(valid), 32'h1);
      chk("frz_hold_code", 32'(code), 32'h2);
    end
    req = '0;
    chk("frz_pend", 32'(pend), 32'h44);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("frz_ack_valid", 32'(valid), 32'h0);
    chk("frz_ack_pend", 32'(pend), 32'h40);
    step();
    chk("frz_next_valid", 32'(valid), 32'h1);
    chk("frz_next_code", 32'(code), 32'h6);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("frz_end_pend", 32'(pend), 32'h0);

    // Set wins over clear on the same bit
    req = 8'h20;
    step();
    step();
    chk("sw_code", 32'(code), 32'h5);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("sw_ack_valid", 32'(valid), 32'h0);
    chk("sw_ack_pend", 32'(pend), 32'h20);
    step();
    chk("sw_regrant_valid", 32'(valid), 32'h1);
    chk("sw_regrant_code", 32'(code), 32'h5);
    req = '0;
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("sw_end_pend", 32'(pend), 32'h0);

    // Held requests with an ack on every grant
`ifdef ROTATE_PRIO_EN
    exp_rot = '{7, 1, 0, 7, 1, 0};
`else
    exp_rot = '{7, 7, 7, 7, 7, 7};
`endif
    req = 8'h83;
    step();
    step();
    for (int g = 0; g < 6; g++) begin
      chk("seq_valid", 32'(valid), 32'h1);
      chk("seq_code", 32'(code), 32'(exp_rot[g]));
      ack = 1'b1;
      step();
      ack = 1'b0;
      step();
    end

    // Reset mid-PRESENT, colliding with ack and a full request word
    chk("pre_rst_valid", 32'(valid), 32'h1);
    rst_n = 1'b0;
    ack   = 1'b1;
    req   = 8'hFF;
    step();
    chk("midrst_pend", 32'(pend), 32'h0);
    chk("midrst_valid", 32'(valid), 32'h0);
    chk("midrst_code", 32'(code), 32'h0);
    rst_n = 1'b1;
    ack   = 1'b0;
    req   = '0;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("postrst_valid", 32'(valid), 32'h0);
      chk("postrst_pend", 32'(pend), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
